// File: rtl/pixel_writer_if.sv
// Pixel-stream and video-memory signals of the pixel writer.
// The slave modport is the writer's view; master is the surrounding environment.
interface pixel_writer_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              PIX_VALID;
    logic [7:0]        Xcoord;
    logic [7:0]        Ycoord;
    logic [7:0]        COLOR;
    logic              PIX_READY;
    logic              DONE_IN;
    logic              DONE_OUT;
    logic              MEM_REQ;
    logic              MEM_ACK;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [7:0]        MEM_WDATA;
    logic [7:0]        CLIP_CNT;
    logic              OVERFLOW;

    modport slave (
        input  PIX_VALID, Xcoord, Ycoord, COLOR, DONE_IN, MEM_ACK,
        output PIX_READY, DONE_OUT, MEM_REQ, MEM_ADDR, MEM_WDATA, CLIP_CNT, OVERFLOW
    );

    modport master (
        output PIX_VALID, Xcoord, Ycoord, COLOR, DONE_IN, MEM_ACK,
        input  PIX_READY, DONE_OUT, MEM_REQ, MEM_ADDR, MEM_WDATA, CLIP_CNT, OVERFLOW
    );
endinterface

// File: rtl/pixel_writer.sv
// Buffers draw-stage pixels, clips them to the framebuffer and writes the survivors
// to video memory over req/ack; signals when a command has fully drained.
module pixel_writer #(
    parameter int unsigned FB_WIDTH   = 160,
    parameter int unsigned FB_HEIGHT  = 120,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic           ACLK,
    input  logic           RESET,
    pixel_writer_if.slave  pw
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CALC, REQ} state_t;

    logic [23:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;
    logic [7:0]       cur_x;
    logic [7:0]       cur_y;
    logic [7:0]       cur_c;
    logic             done_pend;

    logic push;
    logic pop;
    logic done_fire;
    logic clipped;

    assign pw.PIX_READY = !RESET && (count != FULL);

    always_comb begin
        push      = pw.PIX_VALID && pw.PIX_READY;
        pop       = (state == IDLE) && (count != '0);
        // A push this cycle means the command still has a pixel on its way in.
        done_fire = done_pend && (state == IDLE) && (count == '0) && !push;
        clipped   = (32'(cur_x) >= FB_WIDTH) || (32'(cur_y) >= FB_HEIGHT);
    end

    always_ff @(posedge ACLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pw.Xcoord, pw.Ycoord, pw.COLOR};
        end
    end

    always_ff @(posedge ACLK) begin
        if (RESET) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            state        <= IDLE;
            cur_x        <= '0;
            cur_y        <= '0;
            cur_c        <= '0;
            done_pend    <= 1'b0;
            pw.DONE_OUT  <= 1'b0;
            pw.MEM_REQ   <= 1'b0;
            pw.MEM_ADDR  <= '0;
            pw.MEM_WDATA <= '0;
            pw.CLIP_CNT  <= '0;
            pw.OVERFLOW  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end

            if (pw.PIX_VALID && !pw.PIX_READY) begin
                pw.OVERFLOW <= 1'b1;
            end

            pw.DONE_OUT <= done_fire;
            if (done_fire) begin
                done_pend <= 1'b0;
            end else if (pw.DONE_IN) begin
                done_pend <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        {cur_x, cur_y, cur_c} <= fifo_mem[rd_ptr];
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (clipped) begin
                        if (pw.CLIP_CNT != 8'hFF) begin
                            pw.CLIP_CNT <= pw.CLIP_CNT + 8'd1;
                        end
                        state <= IDLE;
                    end else begin
                        pw.MEM_ADDR  <= ADDR_W'(32'(cur_y) * FB_WIDTH + 32'(cur_x));
                        pw.MEM_WDATA <= cur_c;
                        pw.MEM_REQ   <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (pw.MEM_ACK) begin
                        pw.MEM_REQ <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: a queue-based model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_pixel_writer;
    localparam int unsigned W  = 160;
    localparam int unsigned H  = 120;
    localparam int unsigned AW = 15;
    localparam int unsigned D  = 8;

    logic ACLK  = 1'b0;
    logic RESET = 1'b1;

    pixel_writer_if #(.ADDR_W(AW)) pw ();

    pixel_writer #(
        .FB_WIDTH  (W),
        .FB_HEIGHT (H),
        .ADDR_W    (AW),
        .FIFO_DEPTH(D)
    ) dut (
        .ACLK (ACLK),
        .RESET(RESET),
        .pw   (pw)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: a bounded queue of pixels plus the single pixel being processed.
    logic [23:0] mq[$];
    bit          m_busy, m_req, m_ovf, m_pend, m_done, started;
    logic [7:0]  m_x, m_y, m_c;
    int          m_clip, m_addr, m_wdata;
    int          la[$];
    int          ld[$];
    int          done_pulses, done_wr;

    always @(posedge ACLK) begin
        bit can_push, do_push, fire;
        if (!RESET && pw.MEM_REQ === 1'b1 && pw.MEM_ACK === 1'b1) begin
            la.push_back(int'(pw.MEM_ADDR));
            ld.push_back(int'(pw.MEM_WDATA));
        end
        if (RESET) begin
            mq.delete();
            m_busy = 0; m_req = 0; m_ovf = 0; m_pend = 0; m_done = 0;
            m_clip = 0; m_addr = 0; m_wdata = 0;
            started = 1;
        end else begin
            can_push = mq.size() < D;
            do_push  = pw.PIX_VALID && can_push;
            if (pw.PIX_VALID && !can_push) m_ovf = 1;
            fire = m_pend && !m_busy && mq.size() == 0 && !do_push;
            if (m_req) begin
                if (pw.MEM_ACK) begin
                    m_req  = 0;
                    m_busy = 0;
                end
            end else if (m_busy) begin
                if (m_x >= W || m_y >= H) begin
                    if (m_clip < 255) m_clip++;
                    m_busy = 0;
                end else begin
                    m_req   = 1;
                    m_addr  = (m_y * W + m_x) % (1 << AW);
                    m_wdata = m_c;
                end
            end else if (mq.size() > 0) begin
                {m_x, m_y, m_c} = mq.pop_front();
                m_busy = 1;
            end
            if (do_push) mq.push_back({pw.Xcoord, pw.Ycoord, pw.COLOR});
            m_done = fire;
            if (fire) m_pend = 0;
            else if (pw.DONE_IN) m_pend = 1;
        end
    end

    always @(negedge ACLK) begin
        if (started) begin
            chk("pix_ready", 32'(pw.PIX_READY), 32'(!RESET && mq.size() != D));
            chk("mem_req", 32'(pw.MEM_REQ), 32'(m_req));
            chk("mem_addr", 32'(pw.MEM_ADDR), m_addr);
            chk("mem_wdata", 32'(pw.MEM_WDATA), m_wdata);
            chk("clip_cnt", 32'(pw.CLIP_CNT), m_clip);
            chk("overflow", 32'(pw.OVERFLOW), 32'(m_ovf));
            chk("done_out", 32'(pw.DONE_OUT), 32'(m_done));
            if (pw.DONE_OUT === 1'b1) begin
                done_pulses++;
                done_wr = la.size();
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send(input int x, input int y, input int c);
        pw.Xcoord    = 8'(x);
        pw.Ycoord    = 8'(y);
        pw.COLOR     = 8'(c);
        pw.PIX_VALID = 1'b1;
        tick();
        pw.PIX_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int accepts, n, k;
        pw.PIX_VALID = 0; pw.Xcoord = 0; pw.Ycoord = 0; pw.COLOR = 0;
        pw.DONE_IN = 0; pw.MEM_ACK = 0;
        repeat (3) tick();
        @(negedge ACLK);
        chk("rst_ready", 32'(pw.PIX_READY), 0);
        chk("rst_req", 32'(pw.MEM_REQ), 0);
        RESET = 0;
        tick();
        @(negedge ACLK);
        chk("ready_after_rst", 32'(pw.PIX_READY), 1);

        // Single pixel, ack tied high: request 2 cycles after acceptance, one cycle long.
        pw.MEM_ACK = 1;
        send(3, 2, 8'hAA);
        @(negedge ACLK); chk("t1_req_c1", 32'(pw.MEM_REQ), 0);
        tick(); @(negedge ACLK); chk("t1_req_c2", 32'(pw.MEM_REQ), 0);
        tick(); @(negedge ACLK);
        chk("t1_req_c3", 32'(pw.MEM_REQ), 1);
        chk("t1_addr", 32'(pw.MEM_ADDR), 323);
        chk("t1_wdata", 32'(pw.MEM_WDATA), 32'hAA);
        tick(); @(negedge ACLK); chk("t1_req_drop", 32'(pw.MEM_REQ), 0);

        // Clipping.
        tick();
        la.delete(); ld.delete();
        send(160, 0, 1);
        send(0, 120, 2);
        send(159, 119, 3);
        repeat (15) tick();
        chk("t2_writes", la.size(), 1);
        if (la.size() > 0) begin
            chk("t2_addr", la[0], 19199);
            chk("t2_data", ld[0], 3);
        end
        @(negedge ACLK); chk("t2_clip", 32'(pw.CLIP_CNT), 2);
        tick();

        // Backpressure: 10 pixels with ack low.
        pw.MEM_ACK = 0;
        la.delete(); ld.delete();
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            pw.Xcoord = 8'(i); pw.Ycoord = 8'd1; pw.COLOR = 8'(8'h10 + i);
            pw.PIX_VALID = 1;
            @(negedge ACLK);
            if (pw.PIX_READY === 1'b1) accepts++;
            if (i == 9) chk("t3_ready_full", 32'(pw.PIX_READY), 0);
            tick();
        end
        pw.PIX_VALID = 0;
        chk("t3_accepts", accepts, 9);
        @(negedge ACLK); chk("t3_overflow", 32'(pw.OVERFLOW), 1);
        pw.MEM_ACK = 1;
        repeat (40) tick();
        chk("t3_writes", la.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < la.size()) begin
                chk("t3_addr", la[i], 160 + i);
                chk("t3_data", ld[i], 8'h10 + i);
            end
        end

        // Ack delayed 5 cycles: request held 6 cycles, stable.
        pw.MEM_ACK = 0;
        send(5, 5, 8'h55);
        @(negedge ACLK);
        k = 0;
        while (pw.MEM_REQ !== 1'b1 && k < 10) begin
            @(negedge ACLK);
            k++;
        end
        chk("t4_req_seen", 32'(pw.MEM_REQ), 1);
        n = 0;
        while (pw.MEM_REQ === 1'b1 && n < 20) begin
            n++;
            chk("t4_addr", 32'(pw.MEM_ADDR), 805);
            chk("t4_wdata", 32'(pw.MEM_WDATA), 32'h55);
            if (n == 6) pw.MEM_ACK = 1;
            @(negedge ACLK);
        end
        chk("t4_req_cycles", n, 6);
        tick();

        // DONE with the last of 4 pixels.
        pw.MEM_ACK = 1;
        tick();
        la.delete(); ld.delete();
        done_pulses = 0; done_wr = -1;
        for (int i = 0; i < 4; i++) begin
            pw.Xcoord = 8'(10 + i); pw.Ycoord = 8'd20; pw.COLOR = 8'(8'h30 + i);
            pw.DONE_IN = (i == 3);
            pw.PIX_VALID = 1;
            tick();
        end
        pw.PIX_VALID = 0; pw.DONE_IN = 0;
        repeat (25) tick();
        chk("t5_done_pulses", done_pulses, 1);
        chk("t5_done_after_writes", done_wr, 4);
        chk("t5_writes", la.size(), 4);

        // DONE on an empty, idle pipeline.
        done_pulses = 0;
        pw.DONE_IN = 1;
        tick();
        pw.DONE_IN = 0;
        @(negedge ACLK); chk("t5b_done_c1", 32'(pw.DONE_OUT), 0);
        tick(); @(negedge ACLK); chk("t5b_done_c2", 32'(pw.DONE_OUT), 1);
        tick(); @(negedge ACLK); chk("t5b_done_c3", 32'(pw.DONE_OUT), 0);
        tick();
        chk("t5b_done_pulses", done_pulses, 1);

        // Reset while requesting with 3 pixels buffered.
        pw.MEM_ACK = 0;
        for (int i = 0; i < 4; i++) begin
            pw.Xcoord = 8'(i); pw.Ycoord = 8'd50; pw.COLOR = 8'(8'h60 + i);
            pw.PIX_VALID = 1;
            tick();
        end
        pw.PIX_VALID = 0;
        @(negedge ACLK); chk("t6_req_before", 32'(pw.MEM_REQ), 1);
        RESET = 1;
        tick();
        @(negedge ACLK);
        chk("t6_req_in_rst", 32'(pw.MEM_REQ), 0);
        chk("t6_ready_in_rst", 32'(pw.PIX_READY), 0);
        RESET = 0;
        pw.MEM_ACK = 1;
        la.delete(); ld.delete();
        tick();
        @(negedge ACLK);
        chk("t6_ready_after", 32'(pw.PIX_READY), 1);
        chk("t6_clip", 32'(pw.CLIP_CNT), 0);
        chk("t6_ovf", 32'(pw.OVERFLOW), 0);
        repeat (10) tick();
        chk("t6_no_writes", la.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
